atomic_counter_bank: RTL and testbench
======================================

Name: atomic_counter_bank

Overview:
- Bank of NUM_CH independent CNT_W-bit event counters, read over a BUS_W-bit request/acknowledge bus.
- An atomic first request snapshots the whole selected counter into a shadow register. Beat 0 (LSBs) is returned from that snapshot; the following BEATS-1 non-atomic requests return the remaining beats from the same snapshot, so every multi-beat read is single-copy atomic.
- Sits between SoC event sources and the microcontroller's peripheral bus. Generalises the single 64-bit/32-bit atomic counter to multiple channels and arbitrary width ratios.

Parameters:
- NUM_CH, 4, number of counter channels (>=1).
- CNT_W, 64, counter width in bits; must be an integer multiple of BUS_W.
- BUS_W, 32, read bus width in bits.
- Derived (localparam): BEATS = CNT_W/BUS_W (>=1); CH_W = max(1, clog2(NUM_CH)); BEAT_W = max(1, clog2(BEATS)).

Ports:
- clk  in  1  clock; all flops posedge.
- reset  in  1  asynchronous, active-high reset.
- trig_i  in  NUM_CH  per-channel increment strobe; bit k high increments channel k by 1 that cycle.
- ld_i  in  1  preload strobe.
- ld_ch_i  in  CH_W  channel to preload.
- ld_val_i  in  CNT_W  preload value.
- req_i  in  1  read request.
- atomic_i  in  1  qualifies req_i as the first beat of a read.
- ch_sel_i  in  CH_W  channel to read; sampled only on an atomic request.
- ack_o  out  1  acknowledge, one cycle after req_i.
- count_o  out  BUS_W  read data.
- err_o  out  1  one-cycle protocol-error pulse, aligned with ack_o.

Behaviour:
- Reset: all counters, shadow, beat index, ack_o, count_o and err_o go to 0; FSM goes to IDLE. Reset mid-burst abandons the burst.
- Counter update priority per channel, per cycle: load (ld_i && ld_ch_i==k) > increment (trig_i[k]) > hold.
- Counters wrap from all-ones to 0 silently.
- ld_ch_i >= NUM_CH: the load is ignored.
- ack_o <= req_i every cycle, unconditionally. Back-to-back requests give back-to-back acks.
- FSM has two states, IDLE and BURST, plus a beat index bidx.
- Atomic request (req_i && atomic_i), accepted in any state:
  - shadow <= current register value of channel ch_sel_i. This is the pre-increment/pre-load value of that same cycle.
  - count_o <= that value's bits [BUS_W-1:0].
  - bidx <= 1. FSM goes to BURST if BEATS>1, otherwise stays in IDLE.
  - An atomic request in BURST restarts the snapshot; no error is flagged.
- Non-atomic request in BURST:
  - count_o <= shadow beat bidx; bidx increments.
  - On the last beat (bidx==BEATS-1) the FSM returns to IDLE.
- Non-atomic request in IDLE: count_o <= 0 and err_o <= 1.
- ch_sel_i >= NUM_CH on an atomic request: the snapshot is 0 and err_o <= 1.
- No request: count_o holds its last value; err_o <= 0; FSM and bidx hold. Gaps of any length between beats are legal.
- Triggers arriving during a burst never affect the shadow.

Optional Feature:
- Macro ATOMIC_CNT_CLR_ON_READ_EN.
- Defined:
  - An accepted atomic request to a valid channel also clears that channel.
  - A trig in the same cycle leaves the counter at 1.
  - A load in the same cycle wins over the clear.
- Undefined: reads are non-destructive.

Decomposition:
- Package atomic_cnt_pkg:
  - FSM state enum (ST_IDLE, ST_BURST).
  - Function computing BEATS and checking divisibility; an elaboration-time assertion fires if CNT_W % BUS_W != 0.
- Sub-module atomic_cnt_channel: one CNT_W counter with load/increment/clear-on-read inputs, instantiated NUM_CH times via generate.
- Top level holds the snapshot, FSM, beat mux and ack logic.

Test Plan:
- Defaults. Preload ch1 = 0x0000_0000_FFFF_FFFF; trig_i[1] high continuously; atomic read ch1 with beats back-to-back -> count_o 0xFFFF_FFFF, then 0x0000_0000 (snapshot), although the live counter is by then 0x1_0000_0001.
- Preload ch2 = 0x1234_5678_9ABC_DEF0; atomic req; 5 idle cycles with trig_i[2] pulsing; non-atomic req -> 0x9ABC_DEF0, then 0x1234_5678; ack_o only in the cycles after each req.
- Atomic ch0, then atomic ch3 (preloaded 0xA_0000_0005) before beat 1 -> 0x0, then 0x5; next non-atomic req -> 0xA; no err_o.
- Non-atomic req in IDLE, and a third beat after a completed read -> count_o 0, ack_o 1, err_o 1 for one cycle.
- Preload ch0 = all-ones, trig once -> subsequent read 0,0. Reset asserted between beats -> all outputs 0; a following non-atomic req flags err_o.
- With ATOMIC_CNT_CLR_ON_READ_EN: ch1 = 7, atomic read with simultaneous trig_i[1] -> beats 7,0; re-read -> 1,0.

Source files
------------

// File: rtl/atomic_cnt_pkg.sv
// Shared types and elaboration helpers for the atomic counter bank.
package atomic_cnt_pkg;

    typedef enum logic {ST_IDLE, ST_BURST} state_t;

    function automatic bit beats_ok(input int cnt_w, input int bus_w);
        return (bus_w > 0) && (cnt_w % bus_w == 0) && (cnt_w >= bus_w);
    endfunction

    function automatic int calc_beats(input int cnt_w, input int bus_w);
        return beats_ok(cnt_w, bus_w) ? cnt_w / bus_w : 1;
    endfunction

    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/atomic_cnt_channel.sv
// One event counter: load beats clear-on-read, which beats increment.
module atomic_cnt_channel #(
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ld,
    input  logic [CNT_W-1:0] ld_val,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (ld)
            cnt <= ld_val;
        else if (clr)
            cnt <= CNT_W'(inc);   // an event coinciding with the read is kept
        else if (inc)
            cnt <= cnt + CNT_W'(1);
    end

endmodule

// File: rtl/atomic_counter_bank.sv
// Multi-channel event counter bank with single-copy-atomic multi-beat reads.
// Define ATOMIC_CNT_CLR_ON_READ_EN to make atomic reads clear the channel read.
module atomic_counter_bank
    import atomic_cnt_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 64,
    parameter int BUS_W  = 32
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_CH-1:0]                   trig_i,
    input  logic                                ld_i,
    input  logic [clog2_min1(NUM_CH)-1:0]       ld_ch_i,
    input  logic [CNT_W-1:0]                    ld_val_i,
    input  logic                                req_i,
    input  logic                                atomic_i,
    input  logic [clog2_min1(NUM_CH)-1:0]       ch_sel_i,
    output logic                                ack_o,
    output logic [BUS_W-1:0]                    count_o,
    output logic                                err_o
);

    localparam int BEATS  = calc_beats(CNT_W, BUS_W);
    localparam int CH_W   = clog2_min1(NUM_CH);
    localparam int BEAT_W = clog2_min1(BEATS);

    if (!beats_ok(CNT_W, BUS_W)) begin : g_bad_ratio
        $error("atomic_counter_bank: CNT_W must be an integer multiple of BUS_W");
    end

    logic [NUM_CH-1:0][CNT_W-1:0] cnt;
    logic [NUM_CH-1:0]            ld_hit;
    logic [NUM_CH-1:0]            clr_hit;
    logic [CNT_W-1:0]             sel_val;
    logic                         sel_ok;
    logic [BEATS-1:0][BUS_W-1:0]  shadow;
    logic [BEAT_W-1:0]            bidx;
    state_t                       state;
    logic                         rd_atomic;

    assign rd_atomic = req_i && atomic_i;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        assign ld_hit[k] = ld_i && (ld_ch_i == CH_W'(k));
`ifdef ATOMIC_CNT_CLR_ON_READ_EN
        assign clr_hit[k] = rd_atomic && (ch_sel_i == CH_W'(k));
`else
        assign clr_hit[k] = 1'b0;
`endif
        atomic_cnt_channel #(.CNT_W(CNT_W)) u_ch (
            .clk    (clk),
            .reset  (reset),
            .ld     (ld_hit[k]),
            .ld_val (ld_val_i),
            .inc    (trig_i[k]),
            .clr    (clr_hit[k]),
            .cnt    (cnt[k])
        );
    end

    // Out-of-range selects fall through to a zero snapshot.
    always_comb begin
        sel_val = '0;
        sel_ok  = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ch_sel_i == CH_W'(k)) begin
                sel_val = cnt[k];
                sel_ok  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            bidx    <= '0;
            shadow  <= '0;
            ack_o   <= 1'b0;
            count_o <= '0;
            err_o   <= 1'b0;
        end else begin
            ack_o <= req_i;
            err_o <= 1'b0;
            if (rd_atomic) begin
                shadow  <= sel_val;
                count_o <= sel_val[BUS_W-1:0];
                bidx    <= BEAT_W'(1);
                err_o   <= !sel_ok;
                state   <= (BEATS > 1) ? ST_BURST : ST_IDLE;
            end else if (req_i) begin
                if (state == ST_BURST) begin
                    count_o <= shadow[bidx];
                    bidx    <= bidx + BEAT_W'(1);
                    if (bidx == BEAT_W'(BEATS - 1))
                        state <= ST_IDLE;
                end else begin
                    count_o <= '0;
                    err_o   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_atomic_counter_bank.sv
// Self-checking bench: directed vector table, corner sequences, random vs reference model.
module tb_atomic_counter_bank;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 64;
    localparam int BUS_W  = 32;
    localparam int BEATS  = CNT_W / BUS_W;

    logic              clk = 1'b0;
    logic              reset;
    logic [NUM_CH-1:0] trig_i;
    logic              ld_i;
    logic [1:0]        ld_ch_i;
    logic [CNT_W-1:0]  ld_val_i;
    logic              req_i;
    logic              atomic_i;
    logic [1:0]        ch_sel_i;
    logic              ack_o;
    logic [BUS_W-1:0]  count_o;
    logic              err_o;

    atomic_counter_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .BUS_W(BUS_W)) dut (
        .clk(clk), .reset(reset), .trig_i(trig_i), .ld_i(ld_i), .ld_ch_i(ld_ch_i),
        .ld_val_i(ld_val_i), .req_i(req_i), .atomic_i(atomic_i), .ch_sel_i(ch_sel_i),
        .ack_o(ack_o), .count_o(count_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: live counters plus a queue of beats still owed from the last snapshot.
    logic [CNT_W-1:0] m_cnt [NUM_CH];
    logic [BUS_W-1:0] m_q [$];
    logic             m_ack;
    logic [BUS_W-1:0] m_count;
    logic             m_err;

    typedef struct {
        logic [3:0]  trig;
        logic        ld;
        logic [1:0]  ld_ch;
        logic [63:0] ld_val;
        logic        req;
        logic        atomic;
        logic [1:0]  ch_sel;
        logic        e_ack;
        logic [31:0] e_cnt;
        logic        e_err;
    } vec_t;

    vec_t tbl [$];

    function automatic vec_t mk(input logic [3:0] tr, input logic l, input logic [1:0] lc,
                                input logic [63:0] lv, input logic r, input logic a,
                                input logic [1:0] cs, input logic ea, input logic [31:0] ec,
                                input logic ee);
        vec_t v;
        v.trig = tr; v.ld = l; v.ld_ch = lc; v.ld_val = lv; v.req = r; v.atomic = a;
        v.ch_sel = cs; v.e_ack = ea; v.e_cnt = ec; v.e_err = ee;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NUM_CH; k++) m_cnt[k] = '0;
        m_q.delete();
        m_ack = 1'b0; m_count = '0; m_err = 1'b0;
    endtask

    task automatic model_step(input logic [3:0] tr, input logic l, input logic [1:0] lc,
                              input logic [63:0] lv, input logic r, input logic a,
                              input logic [1:0] cs);
        logic [CNT_W-1:0] snap;
        m_ack = r;
        m_err = 1'b0;
        if (r && a) begin
            snap = (int'(cs) < NUM_CH) ? m_cnt[cs] : '0;
            m_err = (int'(cs) >= NUM_CH);
            m_q.delete();
            m_count = snap[BUS_W-1:0];
            for (int b = 1; b < BEATS; b++) m_q.push_back(snap[b*BUS_W +: BUS_W]);
        end else if (r) begin
            if (m_q.size() > 0) m_count = m_q.pop_front();
            else begin m_count = '0; m_err = 1'b1; end
        end
        for (int k = 0; k < NUM_CH; k++) begin
            if (l && int'(lc) == k) m_cnt[k] = lv;
`ifdef ATOMIC_CNT_CLR_ON_READ_EN
            else if (r && a && int'(cs) == k) m_cnt[k] = tr[k] ? 64'd1 : 64'd0;
`endif
            else if (tr[k]) m_cnt[k] = m_cnt[k] + 1;
        end
    endtask

    task automatic step(input logic [3:0] tr, input logic l, input logic [1:0] lc,
                        input logic [63:0] lv, input logic r, input logic a, input logic [1:0] cs);
        trig_i = tr; ld_i = l; ld_ch_i = lc; ld_val_i = lv; req_i = r; atomic_i = a; ch_sel_i = cs;
        model_step(tr, l, lc, lv, r, a, cs);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(4'b0, 1'b0, 2'd0, 64'd0, 1'b0, 1'b0, 2'd0);
    endtask

    task automatic chk_outs(input string tag, input logic ea, input logic [31:0] ec, input logic ee);
        chk({tag, "_ack"}, {63'd0, ack_o}, {63'd0, ea});
        chk({tag, "_cnt"}, {32'd0, count_o}, {32'd0, ec});
        chk({tag, "_err"}, {63'd0, err_o}, {63'd0, ee});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        trig_i = '0; ld_i = 0; ld_ch_i = 0; ld_val_i = '0; req_i = 0; atomic_i = 0; ch_sel_i = 0;
        model_reset();
        @(posedge clk); @(posedge clk); #2;
        reset = 1'b0;
    endtask

    initial begin
        // Directed vectors, one row per clock; expected outputs sampled after that edge.
        tbl.push_back(mk(4'b0000, 1, 2'd1, 64'h0000_0000_FFFF_FFFF, 0, 0, 2'd0, 0, 32'h0, 0));
        tbl.push_back(mk(4'b0010, 0, 2'd0, 64'h0, 1, 1, 2'd1, 1, 32'hFFFF_FFFF, 0));
        tbl.push_back(mk(4'b0010, 0, 2'd0, 64'h0, 1, 0, 2'd0, 1, 32'h0000_0000, 0));
        tbl.push_back(mk(4'b0000, 1, 2'd2, 64'h1234_5678_9ABC_DEF0, 0, 0, 2'd0, 0, 32'h0, 0));
        tbl.push_back(mk(4'b0000, 0, 2'd0, 64'h0, 1, 1, 2'd2, 1, 32'h9ABC_DEF0, 0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk((i % 2 == 0) ? 4'b0100 : 4'b0000, 0, 2'd0, 64'h0, 0, 0, 2'd0,
                             0, 32'h9ABC_DEF0, 0));
        tbl.push_back(mk(4'b0000, 0, 2'd0, 64'h0, 1, 0, 2'd0, 1, 32'h1234_5678, 0));
        tbl.push_back(mk(4'b0000, 1, 2'd3, 64'hA_0000_0005, 0, 0, 2'd0, 0, 32'h1234_5678, 0));
        tbl.push_back(mk(4'b0000, 0, 2'd0, 64'h0, 1, 1, 2'd0, 1, 32'h0, 0));
        tbl.push_back(mk(4'b0000, 0, 2'd0, 64'h0, 1, 1, 2'd3, 1, 32'h5, 0));
        tbl.push_back(mk(4'b0000, 0, 2'd0, 64'h0, 1, 0, 2'd0, 1, 32'hA, 0));
        tbl.push_back(mk(4'b0000, 0, 2'd0, 64'h0, 1, 0, 2'd0, 1, 32'h0, 1));
        tbl.push_back(mk(4'b0000, 0, 2'd0, 64'h0, 0, 0, 2'd0, 0, 32'h0, 0));
        tbl.push_back(mk(4'b0000, 1, 2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 2'd0, 0, 32'h0, 0));
        tbl.push_back(mk(4'b0001, 0, 2'd0, 64'h0, 0, 0, 2'd0, 0, 32'h0, 0));
        tbl.push_back(mk(4'b0000, 0, 2'd0, 64'h0, 1, 1, 2'd0, 1, 32'h0, 0));
        tbl.push_back(mk(4'b0000, 0, 2'd0, 64'h0, 1, 0, 2'd0, 1, 32'h0, 0));

        do_reset();
        chk_outs("reset", 1'b0, 32'h0, 1'b0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].trig, tbl[i].ld, tbl[i].ld_ch, tbl[i].ld_val,
                 tbl[i].req, tbl[i].atomic, tbl[i].ch_sel);
            chk_outs($sformatf("vec%0d", i), tbl[i].e_ack, tbl[i].e_cnt, tbl[i].e_err);
        end

        // Reset between beats abandons the burst and clears the counters.
        step(4'b0, 1'b0, 2'd0, 64'd0, 1'b1, 1'b1, 2'd2);
        chk_outs("pre_rst", 1'b1, m_count, 1'b0);
        reset = 1'b1;
        #2;
        chk_outs("mid_rst", 1'b0, 32'h0, 1'b0);
        model_reset();
        @(posedge clk); #2;
        reset = 1'b0;
        step(4'b0, 1'b0, 2'd0, 64'd0, 1'b1, 1'b0, 2'd0);
        chk_outs("post_rst_beat", 1'b1, 32'h0, 1'b1);
        step(4'b0, 1'b0, 2'd0, 64'd0, 1'b1, 1'b1, 2'd2);
        chk_outs("post_rst_cnt", 1'b1, 32'h0, 1'b0);
        idle();

`ifdef ATOMIC_CNT_CLR_ON_READ_EN
        step(4'b0000, 1'b1, 2'd1, 64'd7, 1'b0, 1'b0, 2'd0);
        step(4'b0010, 1'b0, 2'd0, 64'd0, 1'b1, 1'b1, 2'd1);
        chk_outs("clr_b0", 1'b1, 32'd7, 1'b0);
        step(4'b0000, 1'b0, 2'd0, 64'd0, 1'b1, 1'b0, 2'd0);
        chk_outs("clr_b1", 1'b1, 32'd0, 1'b0);
        step(4'b0000, 1'b0, 2'd0, 64'd0, 1'b1, 1'b1, 2'd1);
        chk_outs("clr_reread_b0", 1'b1, 32'd1, 1'b0);
        step(4'b0000, 1'b0, 2'd0, 64'd0, 1'b1, 1'b0, 2'd0);
        chk_outs("clr_reread_b1", 1'b1, 32'd0, 1'b0);
`endif

        // Random traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            logic [3:0]  tr;
            logic        l, r, a;
            logic [1:0]  lc, cs;
            logic [63:0] lv;
            tr = 4'($urandom);
            l  = ($urandom_range(0, 9) == 0);
            lc = 2'($urandom);
            lv = ($urandom_range(0, 1) == 0) ? {$urandom, $urandom}
                                            : (64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 3)));
            r  = ($urandom_range(0, 2) != 0);
            a  = ($urandom_range(0, 2) == 0);
            cs = 2'($urandom);
            step(tr, l, lc, lv, r, a, cs);
            chk_outs("rnd", m_ack, m_count, m_err);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
